// File: rtl/device_ctrl_pkg.sv
// rtl/device_ctrl_pkg.sv - shared types and constants for the device request sequencer
package device_ctrl_pkg;

  localparam int DEF_ADDRESS_W = 2;
  localparam int DEF_DATA_W    = 8;

  localparam int SINGLE_BEATS  = 1;
  localparam int DUAL_BEATS    = 2;

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    BEAT1,
    WAIT_RD,
    RESP
  } state_t;

endpackage

// File: rtl/device_ctrl.sv
// rtl/device_ctrl.sv - request sequencer for the small addressed memory device
// Serialises one request at a time into single/dual device beats and returns one response.
module device_ctrl
  import device_ctrl_pkg::*;
#(
  parameter int ADDRESS_W = DEF_ADDRESS_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic                 req_dual,
  input  logic [ADDRESS_W-1:0] req_addr,
  input  logic [DATA_W-1:0]    req_wdata0,
  input  logic [DATA_W-1:0]    req_wdata1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_err,
  output logic [DATA_W-1:0]    rsp_rdata0,
  output logic [DATA_W-1:0]    rsp_rdata1,
  output logic [ADDRESS_W-1:0] address,
  output logic                 write_en,
  output logic                 write_dual_en,
  output logic                 read_en,
  output logic                 read_dual_en,
  output logic [DATA_W-1:0]    data_wr,
  input  logic [DATA_W-1:0]    data_rd
);

  state_t               state_q, state_d;
  logic                 ready_q;
  logic                 write_q, write_d;
  logic                 dual_q, dual_d;
  logic                 err_q, err_d;
  logic [ADDRESS_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]    wdata1_q, wdata1_d;
  logic [DATA_W-1:0]    data_wr_q, data_wr_d;
  logic [DATA_W-1:0]    rdata0_q, rdata0_d;
  logic [DATA_W-1:0]    rdata1_q, rdata1_d;
  logic                 accept;
  logic                 reject;

  // ready_q is only ever high while IDLE, so it doubles as the accept qualifier
  assign accept = ready_q && req_valid;
  assign reject = req_dual &&
                  ((int'(req_addr) + DUAL_BEATS - SINGLE_BEATS) >= (1 << ADDRESS_W));

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    dual_d        = dual_q;
    err_d         = err_q;
    addr_d        = addr_q;
    wdata1_d      = wdata1_q;
    data_wr_d     = data_wr_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    write_en      = 1'b0;
    write_dual_en = 1'b0;
    read_en       = 1'b0;
    read_dual_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d  = req_write;
          dual_d   = req_dual;
          err_d    = reject;
          wdata1_d = req_wdata1;
          rdata0_d = '0;
          rdata1_d = '0;
          state_d  = BEAT0;
          if (!reject) begin
            addr_d = req_addr;
            if (req_write) data_wr_d = req_wdata0;
          end
        end
      end
      // A rejected request spends its decode cycle here with every enable gated off
      BEAT0: begin
        if (err_q) begin
          state_d = RESP;
        end else begin
          write_en      = write_q & ~dual_q;
          write_dual_en = write_q & dual_q;
          read_en       = ~write_q & ~dual_q;
          read_dual_en  = ~write_q & dual_q;
          if (dual_q) begin
            state_d = BEAT1;
            if (write_q) data_wr_d = wdata1_q;
          end else begin
            state_d = write_q ? RESP : WAIT_RD;
          end
        end
      end
      BEAT1: begin
        write_dual_en = write_q;
        read_dual_en  = ~write_q;
        if (!write_q) rdata0_d = data_rd;
        state_d = write_q ? RESP : WAIT_RD;
      end
      WAIT_RD: begin
        if (dual_q) rdata1_d = data_rd;
        else        rdata0_d = data_rd;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      write_q   <= 1'b0;
      dual_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata1_q  <= '0;
      data_wr_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == IDLE);
      write_q   <= write_d;
      dual_q    <= dual_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata1_q  <= wdata1_d;
      data_wr_q <= data_wr_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_err    = rsp_valid & err_q;
  assign rsp_rdata0 = rsp_valid ? rdata0_q : '0;
  assign rsp_rdata1 = rsp_valid ? rdata1_q : '0;
  assign address    = addr_q;
  assign data_wr    = data_wr_q;

endmodule

// File: tb/tb_device_ctrl.sv
// tb/tb_device_ctrl.sv - randomized bench for device_ctrl against a transaction-level memory model
module tb_device_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int LOG_N = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic          req_write = 1'b0, req_dual = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata0 = '0, req_wdata1 = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [DW-1:0] rsp_rdata0, rsp_rdata1;
  logic [AW-1:0] address;
  logic          write_en, write_dual_en, read_en, read_dual_en;
  logic [DW-1:0] data_wr, data_rd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  device_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_dual(req_dual),
    .req_addr(req_addr), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .rsp_rdata0(rsp_rdata0), .rsp_rdata1(rsp_rdata1),
    .address(address), .write_en(write_en), .write_dual_en(write_dual_en),
    .read_en(read_en), .read_dual_en(read_dual_en), .data_wr(data_wr), .data_rd(data_rd)
  );

  // Attached memory device: resets to 0xFF, one-cycle read latency, dual beats use an offset toggle
  logic [DW-1:0] mem [4];
  logic          off;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= 8'hFF;
      off     <= 1'b0;
      data_rd <= '0;
    end else begin
      if (write_en) mem[address] <= data_wr;
      if (write_dual_en) begin
        mem[address + {1'b0, off}] <= data_wr;
        off <= ~off;
      end
      if (read_en) data_rd <= mem[address];
      if (read_dual_en) begin
        data_rd <= mem[address + {1'b0, off}];
        off <= ~off;
      end
    end
  end

  // Enable log: every cycle with a device enable high is recorded
  int            cyc = 0, en_n = 0, onehot_viol = 0;
  logic [3:0]    mon_k;
  logic [3:0]    en_kind [LOG_N];
  logic [AW-1:0] en_addr [LOG_N];
  logic [DW-1:0] en_data [LOG_N];
  int            en_cyc  [LOG_N];
  always @(negedge clk) begin
    cyc++;
    mon_k = {read_dual_en, read_en, write_dual_en, write_en};
    if (rst && mon_k != 4'b0) begin
      if ($countones(mon_k) > 1) onehot_viol++;
      en_kind[en_n % LOG_N] = mon_k;
      en_addr[en_n % LOG_N] = address;
      en_data[en_n % LOG_N] = data_wr;
      en_cyc[en_n % LOG_N]  = cyc;
      en_n++;
    end
  end

  logic [DW-1:0] ref_mem [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1);
  endtask

  task automatic do_txn(input logic w, input logic d, input logic [AW-1:0] a,
                        input logic [DW-1:0] w0, input logic [DW-1:0] w1, input int hold);
    logic          exp_err;
    logic [DW-1:0] e0, e1;
    logic [3:0]    exp_kind;
    logic [AW-1:0] a1;
    int            exp_lat, exp_n, lat, base, n, idx;
    a1       = a + 2'd1;
    exp_err  = d && (a == 2'd3);
    exp_n    = exp_err ? 0 : (d ? 2 : 1);
    exp_lat  = exp_err ? 1 : (w ? (d ? 2 : 1) : (d ? 3 : 2));
    exp_kind = w ? (d ? 4'b0010 : 4'b0001) : (d ? 4'b1000 : 4'b0100);
    e0 = '0;
    e1 = '0;
    if (!exp_err) begin
      if (w) begin
        ref_mem[a] = w0;
        if (d) ref_mem[a1] = w1;
      end else begin
        e0 = ref_mem[a];
        if (d) e1 = ref_mem[a1];
      end
    end

    wait_ready();
    req_valid  = 1'b1;
    req_write  = w;
    req_dual   = d;
    req_addr   = a;
    req_wdata0 = w0;
    req_wdata1 = w1;
    @(posedge clk);
    #1;
    base       = en_n;
    req_valid  = 1'($urandom);
    req_write  = 1'($urandom);
    req_dual   = 1'($urandom);
    req_addr   = 2'($urandom);
    req_wdata0 = 8'($urandom);
    req_wdata1 = 8'($urandom);

    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("req_ready_busy", req_ready, 0);
    for (int i = 0; i <= hold; i++) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_rdata0", rsp_rdata0, e0);
      check("rsp_rdata1", rsp_rdata1, e1);
      if (i < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", rsp_valid, 0);
    check("ready_after_rsp", req_ready, 1);

    n = en_n - base;
    check("en_count", n, exp_n);
    for (int i = 0; i < n && i < exp_n; i++) begin
      idx = (base + i) % LOG_N;
      check("en_kind", en_kind[idx], exp_kind);
      check("en_addr", en_addr[idx], a);
      if (w) check("en_data", en_data[idx], (i == 0) ? w0 : w1);
      if (i > 0) check("en_b2b", en_cyc[idx] - en_cyc[(base + i - 1) % LOG_N], 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w, d;
    int   seen_rsp;
    ref_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {req_ready, rsp_valid, rsp_err, rsp_rdata0, rsp_rdata1, address,
           write_en, write_dual_en, read_en, read_dual_en, data_wr}, 0);
    rst = 1'b1;
    #1;
    check("ready_before_clk", req_ready, 0);
    @(negedge clk);
    check("ready_after_clk", req_ready, 1);

    do_txn(1'b0, 1'b0, 2'd2, 8'h00, 8'h00, 0);
    do_txn(1'b1, 1'b0, 2'd1, 8'h5A, 8'h00, 0);
    do_txn(1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 0);
    do_txn(1'b1, 1'b1, 2'd0, 8'h11, 8'h22, 0);
    do_txn(1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 0);
    do_txn(1'b1, 1'b1, 2'd3, 8'hAA, 8'hBB, 0);
    do_txn(1'b0, 1'b0, 2'd3, 8'h00, 8'h00, 0);
    do_txn(1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 4);

    // Abort a dual write in its second beat; the device is reset alongside
    wait_ready();
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_dual   = 1'b1;
    req_addr   = 2'd0;
    req_wdata0 = 8'h33;
    req_wdata1 = 8'h44;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("beat1_en", write_dual_en, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_outputs",
          {req_ready, rsp_valid, rsp_err, rsp_rdata0, rsp_rdata1, address,
           write_en, write_dual_en, read_en, read_dual_en, data_wr}, 0);
    ref_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen_rsp = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
    end
    check("no_rsp_after_abort", seen_rsp, 0);
    do_txn(1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 0);

    for (int k = 0; k < 40; k++) begin
      w = 1'($urandom);
      d = 1'($urandom);
      do_txn(w, d, 2'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end

    check("one_hot_enables", onehot_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
